fifo_tlp: RTL and testbench

//  Synchronous first-word-fall-through FIFO for 10-bit transaction-layer words ({dest[1:0], payload[7:0]}).

---
 rtl/pcie_tl_pkg.sv | 26 ++
 rtl/fifo_tlp_if.sv | 35 +++
 rtl/fifo_tlp_mem.sv | 31 +++
 rtl/fifo_tlp.sv | 100 ++++++++++
 tb/tb_fifo_tlp.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/pcie_tl_pkg.sv
// Shared transaction-layer definitions for the TLP datapath blocks.
//   TL_DATA_W   : word width, {dest[1:0], payload[7:0]}
//   TL_DEST_MSB : top bit of the destination field
//   TL_DEST_LSB : bottom bit of the destination field
//   tl_word_t   : one transaction-layer word
//   tl_dest_e   : destination codes DEST0..DEST3
package pcie_tl_pkg;

    localparam int unsigned TL_DATA_W   = 10;
    localparam int unsigned TL_DEST_MSB = 9;
    localparam int unsigned TL_DEST_LSB = 8;

    typedef logic [TL_DATA_W-1:0] tl_word_t;

    typedef enum logic [1:0] {
        DEST0 = 2'd0,
        DEST1 = 2'd1,
        DEST2 = 2'd2,
        DEST3 = 2'd3
    } tl_dest_e;

    function automatic tl_dest_e tl_dest(input tl_word_t w);
        return tl_dest_e'(w[TL_DEST_MSB:TL_DEST_LSB]);
    endfunction

endpackage

// File: rtl/fifo_tlp_if.sv
// Handshake/status bundle between a TLP producer/consumer and fifo_tlp.
//   master : drives wr, data_in, rd; observes data_out, flags, count, errors
//   slave  : the FIFO side
interface fifo_tlp_if #(
    parameter int unsigned DEPTH = 8
);
    import pcie_tl_pkg::*;

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic            wr;
    tl_word_t        data_in;
    logic            rd;
    tl_word_t        data_out;
    logic            empty;
    logic            full;
    logic            almost_empty;
    logic            almost_full;
    logic [ADDR_W:0] count;
    logic            err_overflow;
    logic            err_underflow;

    modport master (
        output wr, data_in, rd,
        input  data_out, empty, full, almost_empty, almost_full, count,
               err_overflow, err_underflow
    );

    modport slave (
        input  wr, data_in, rd,
        output data_out, empty, full, almost_empty, almost_full, count,
               err_overflow, err_underflow
    );

endinterface

// File: rtl/fifo_tlp_mem.sv
// DEPTH x DATA_W register array for fifo_tlp. Not reset.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : read data
module fifo_tlp_mem #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_tlp.sv
// First-word-fall-through FIFO for 10-bit transaction-layer words.
//   clk   : clock, rising edge
//   reset : synchronous, active-high; clears pointers, count and error flags
//   bus   : fifo_tlp_if.slave -- wr/data_in/rd in; data_out, empty, full,
//           almost_empty, almost_full, count, err_overflow, err_underflow out
// Build option: define FIFO_ERR_EN to build the sticky error flags; otherwise
// err_overflow/err_underflow are tied to 0.
module fifo_tlp
    import pcie_tl_pkg::*;
#(
    parameter int unsigned DATA_W    = TL_DATA_W,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AF_THRESH = 6,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic       clk,
    input  logic       reset,
    fifo_tlp_if.slave  bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AfCnt    = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AeCnt    = (ADDR_W + 1)'(AE_THRESH);

    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              empty, full, push, pop;
    logic [DATA_W-1:0] rdata;

    assign empty = (count_q == '0);
    assign full  = (count_q == DepthCnt);

    // A simultaneous pop frees the slot, so a full FIFO still accepts wr&rd.
    assign push = bus.wr && (!full || bus.rd);
    assign pop  = bus.rd && !empty;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            count_q <= count_d;
        end
    end

    fifo_tlp_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (bus.data_in),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign bus.data_out     = empty ? '0 : rdata;
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.almost_empty = (count_q <= AeCnt);
    assign bus.almost_full  = (count_q >= AfCnt);
    assign bus.count        = count_q;

`ifdef FIFO_ERR_EN
    logic ovf_q, udf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (bus.wr && full && !bus.rd) ovf_q <= 1'b1;
            // Covers empty&wr&rd too: the pop half is ignored.
            if (bus.rd && empty)           udf_q <= 1'b1;
        end
    end

    assign bus.err_overflow  = ovf_q;
    assign bus.err_underflow = udf_q;
`else
    assign bus.err_overflow  = 1'b0;
    assign bus.err_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_tlp.sv
// Testbench for fifo_tlp: queue-based reference model checked every cycle on
// the falling edge, plus literal expectations for the directed scenarios.
// Honours FIFO_ERR_EN for the expected error-flag values.
module tb_fifo_tlp;

`ifdef FIFO_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_tlp_if #(.DEPTH(8)) bus ();

    fifo_tlp #(
        .DATA_W    (10),
        .DEPTH     (8),
        .AF_THRESH (6),
        .AE_THRESH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference model: plain queue of stored words plus sticky error bits.
    logic [9:0] m_q[$];
    bit         m_ovf, m_udf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_apply(input bit w, input logic [9:0] d, input bit r, input bit rst);
        bit was_full, was_empty;
        if (rst) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            return;
        end
        was_full  = (m_q.size() == 8);
        was_empty = (m_q.size() == 0);
        if (r && !was_empty) void'(m_q.pop_front());
        if (w && (!was_full || r)) m_q.push_back(d);
        if (w && was_full && !r) m_ovf = ErrEn;
        if (r && was_empty)      m_udf = ErrEn;
    endtask

    // One clock: drive inputs, advance the model, settle to just after negedge.
    task automatic step(input bit w, input logic [9:0] d, input bit r, input bit rst);
        bus.wr      = w;
        bus.data_in = d;
        bus.rd      = r;
        reset       = rst;
        model_apply(w, d, r, rst);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_data_out", 32'(bus.data_out), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
            chk("m_count",    32'(bus.count),        32'(m_q.size()));
            chk("m_empty",    32'(bus.empty),        32'(m_q.size() == 0));
            chk("m_full",     32'(bus.full),         32'(m_q.size() == 8));
            chk("m_aempty",   32'(bus.almost_empty), 32'(m_q.size() <= 2));
            chk("m_afull",    32'(bus.almost_full),  32'(m_q.size() >= 6));
            chk("m_err_ovf",  32'(bus.err_overflow),  32'(m_ovf));
            chk("m_err_udf",  32'(bus.err_underflow), 32'(m_udf));
        end
    end

    initial begin
        logic [9:0] drain [8];
        drain = '{10'h003, 10'h004, 10'h005, 10'h006, 10'h007, 10'h100, 10'h101, 10'h102};

        bus.wr = 1'b0; bus.data_in = '0; bus.rd = 1'b0; reset = 1'b1;
        step(0, 10'h0, 0, 1);
        step(0, 10'h0, 0, 1);
        chk_en = 1'b1;

        // 1: reset then idle
        step(0, 10'h0, 0, 0);
        chk("t1_empty",  32'(bus.empty), 32'd1);
        chk("t1_full",   32'(bus.full), 32'd0);
        chk("t1_ae",     32'(bus.almost_empty), 32'd1);
        chk("t1_af",     32'(bus.almost_full), 32'd0);
        chk("t1_count",  32'(bus.count), 32'd0);
        chk("t1_data",   32'(bus.data_out), 32'd0);

        // 2: single push, fall-through, pop back to empty
        step(1, 10'h1A5, 0, 0);
        chk("t2_data",  32'(bus.data_out), 32'h1A5);
        chk("t2_count", 32'(bus.count), 32'd1);
        chk("t2_empty", 32'(bus.empty), 32'd0);
        step(0, 10'h0, 1, 0);
        chk("t2_empty2", 32'(bus.empty), 32'd1);
        chk("t2_data2",  32'(bus.data_out), 32'd0);

        // 3: fill to full, check thresholds, overflow on 9th push
        for (int i = 0; i < 8; i++) begin
            step(1, 10'(i), 0, 0);
            chk("t3_count", 32'(bus.count), 32'(i + 1));
            chk("t3_af",    32'(bus.almost_full), 32'(i >= 5));
            chk("t3_ae",    32'(bus.almost_empty), 32'(i <= 1));
            chk("t3_head",  32'(bus.data_out), 32'h000);
        end
        chk("t3_full", 32'(bus.full), 32'd1);
        step(1, 10'h3FF, 0, 0);
        chk("t3_count9", 32'(bus.count), 32'd8);
        chk("t3_ovf",    32'(bus.err_overflow), 32'(ErrEn));

        // 4: full with simultaneous wr/rd; pops return 000..002, count holds
        for (int i = 0; i < 3; i++) begin
            chk("t4_head", 32'(bus.data_out), 32'(i));
            step(1, 10'h100 + 10'(i), 1, 0);
            chk("t4_count", 32'(bus.count), 32'd8);
        end
        for (int i = 0; i < 8; i++) begin
            chk("t4_drain", 32'(bus.data_out), 32'(drain[i]));
            step(0, 10'h0, 1, 0);
        end
        chk("t4_empty", 32'(bus.empty), 32'd1);

        // 5: empty with wr&rd -> push only, underflow
        step(1, 10'h2C3, 1, 0);
        chk("t5_count", 32'(bus.count), 32'd1);
        chk("t5_data",  32'(bus.data_out), 32'h2C3);
        chk("t5_udf",   32'(bus.err_underflow), 32'(ErrEn));

        // 6: count 5, reset with wr asserted
        for (int i = 0; i < 4; i++) step(1, 10'h040 + 10'(i), 0, 0);
        chk("t6_count5", 32'(bus.count), 32'd5);
        step(1, 10'h055, 0, 1);
        chk("t6_count", 32'(bus.count), 32'd0);
        chk("t6_empty", 32'(bus.empty), 32'd1);
        chk("t6_ovf",   32'(bus.err_overflow), 32'd0);
        chk("t6_udf",   32'(bus.err_underflow), 32'd0);
        step(0, 10'h0, 0, 0);
        chk("t6_data",  32'(bus.data_out), 32'd0);
        step(1, 10'h0AA, 0, 0);
        chk("t6_fresh", 32'(bus.data_out), 32'h0AA);
        step(0, 10'h0, 1, 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
